// File: rtl/mcm_poll_ctrl_if.sv
// Poll controller bus: receiver handshake plus frame/error status.
// Signals:
//   enable      polling enable level (driven by the slave side)
//   done        receiver done level (driven by the slave side)
//   rq          request pulse to the receiver
//   busy        high while a request is outstanding
//   frame_ready one-clock frame-complete pulse
//   timeout     one-clock pulse per timed-out request
//   err         one-clock pulse per abandoned request
//   frame_cnt   completed frame count (wraps)
//   err_cnt     abandoned request count (saturates)
// Modports: master = poll controller, slave = receiver/downstream side.
interface mcm_poll_ctrl_if;
  logic        enable;
  logic        done;
  logic        rq;
  logic        busy;
  logic        frame_ready;
  logic        timeout;
  logic        err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  modport master (
    input  enable, done,
    output rq, busy, frame_ready, timeout, err, frame_cnt, err_cnt
  );

  modport slave (
    output enable, done,
    input  rq, busy, frame_ready, timeout, err, frame_cnt, err_cnt
  );
endinterface

// File: rtl/mcm_poll_ctrl.sv
// Periodic request scheduler for the MCM coordinate receiver. Issues an
// RQ_LEN-clock request every PERIOD clocks, waits up to TIMEOUT clocks for the
// receiver's done level, then reports frame-ready or timeout/error.
// Optional feature macro MCM_POLL_RETRY_EN: on timeout, re-request up to
// MAX_RETRY times before abandoning the request.
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    mcm_poll_ctrl_if.master (enable/done in; rq, busy, pulses, counters out)
module mcm_poll_ctrl #(
  parameter logic [23:0] PERIOD    = 24'd1000000,
  parameter logic [7:0]  RQ_LEN    = 8'd4,
  parameter logic [23:0] TIMEOUT   = 24'd500000
`ifdef MCM_POLL_RETRY_EN
  ,
  parameter logic [3:0]  MAX_RETRY = 4'd2
`endif
) (
  input  logic           clk,
  input  logic           reset,
  mcm_poll_ctrl_if.master bus
);

  localparam int unsigned TW  = 24;
  localparam int unsigned RW  = 8;
  localparam int unsigned FCW = 16;
  localparam int unsigned ECW = 8;

  localparam logic [TW-1:0] PER_LAST = PERIOD - TW'(1);
  localparam logic [TW-1:0] TMO_LAST = TIMEOUT - TW'(1);
  localparam logic [RW-1:0] RQ_LAST  = RQ_LEN - RW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   rq_cnt, rq_cnt_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [TW-1:0]   per_cnt, per_cnt_nxt;
  logic [FCW-1:0]  frame_cnt, frame_cnt_nxt;
  logic [ECW-1:0]  err_cnt, err_cnt_nxt;
  logic            rq, rq_nxt;
  logic            busy, busy_nxt;
  logic            frame_ready, frame_ready_nxt;
  logic            timeout, timeout_nxt;
  logic            err, err_nxt;
`ifdef MCM_POLL_RETRY_EN
  logic [3:0]      retry_cnt, retry_cnt_nxt;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      rq_cnt      <= '0;
      tmr         <= '0;
      per_cnt     <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      rq          <= 1'b0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      timeout     <= 1'b0;
      err         <= 1'b0;
`ifdef MCM_POLL_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      state       <= state_nxt;
      rq_cnt      <= rq_cnt_nxt;
      tmr         <= tmr_nxt;
      per_cnt     <= per_cnt_nxt;
      frame_cnt   <= frame_cnt_nxt;
      err_cnt     <= err_cnt_nxt;
      rq          <= rq_nxt;
      busy        <= busy_nxt;
      frame_ready <= frame_ready_nxt;
      timeout     <= timeout_nxt;
      err         <= err_nxt;
`ifdef MCM_POLL_RETRY_EN
      retry_cnt   <= retry_cnt_nxt;
`endif
    end
  end

  // Next-state, counter updates and next output values
  always_comb begin
    state_nxt       = state;
    rq_cnt_nxt      = rq_cnt;
    tmr_nxt         = tmr;
    // Period counter runs from request start and parks at PERIOD-1
    per_cnt_nxt     = (per_cnt == PER_LAST) ? per_cnt : per_cnt + TW'(1);
    frame_cnt_nxt   = frame_cnt;
    err_cnt_nxt     = err_cnt;
    frame_ready_nxt = 1'b0;
    timeout_nxt     = 1'b0;
    err_nxt         = 1'b0;
`ifdef MCM_POLL_RETRY_EN
    retry_cnt_nxt   = retry_cnt;
`endif

    unique case (state)
      S_IDLE: begin
        if (bus.enable) begin
          state_nxt   = S_REQ;
          rq_cnt_nxt  = '0;
          per_cnt_nxt = '0;
        end
      end

      S_REQ: begin
        rq_cnt_nxt = rq_cnt + RW'(1);
        if (rq_cnt == RQ_LAST) begin
          state_nxt = S_WAIT;
          tmr_nxt   = '0;
        end
      end

      S_WAIT: begin
        tmr_nxt = tmr + TW'(1);
        // done wins over a timeout landing on the same cycle
        if (bus.done) begin
          state_nxt = S_DONE;
        end else if (tmr == TMO_LAST) begin
          timeout_nxt = 1'b1;
`ifdef MCM_POLL_RETRY_EN
          if (retry_cnt < MAX_RETRY) begin
            retry_cnt_nxt = retry_cnt + 4'(1);
            state_nxt     = S_REQ;
            rq_cnt_nxt    = '0;
            per_cnt_nxt   = '0;
          end else begin
            err_nxt       = 1'b1;
            err_cnt_nxt   = (err_cnt == '1) ? err_cnt : err_cnt + ECW'(1);
            retry_cnt_nxt = '0;
            state_nxt     = S_GAP;
          end
`else
          err_nxt     = 1'b1;
          err_cnt_nxt = (err_cnt == '1) ? err_cnt : err_cnt + ECW'(1);
          state_nxt   = S_GAP;
`endif
        end
      end

      S_DONE: begin
        frame_ready_nxt = 1'b1;
        frame_cnt_nxt   = frame_cnt + FCW'(1);
`ifdef MCM_POLL_RETRY_EN
        retry_cnt_nxt   = '0;
`endif
        state_nxt       = S_GAP;
      end

      S_GAP: begin
        // An overrun (already at PERIOD-1) exits on the next edge
        if (per_cnt == PER_LAST) begin
          if (bus.enable) begin
            state_nxt   = S_REQ;
            rq_cnt_nxt  = '0;
            per_cnt_nxt = '0;
          end else begin
            state_nxt   = S_IDLE;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // Level outputs follow the state being entered
    rq_nxt   = (state_nxt == S_REQ);
    busy_nxt = (state_nxt == S_REQ) || (state_nxt == S_WAIT);
  end

  assign bus.rq          = rq;
  assign bus.busy        = busy;
  assign bus.frame_ready = frame_ready;
  assign bus.timeout     = timeout;
  assign bus.err         = err;
  assign bus.frame_cnt   = frame_cnt;
  assign bus.err_cnt     = err_cnt;

endmodule

// File: tb/tb_mcm_poll_ctrl.sv
// Testbench for mcm_poll_ctrl: directed sequence with randomized done delays,
// checked against an event-timing model of the poll schedule.
module tb_mcm_poll_ctrl;

  localparam int PERIOD    = 1000;
  localparam int RQ_LEN    = 4;
  localparam int TIMEOUT   = 500;
  localparam int MAX_RETRY = 2;

  logic clk;
  logic reset;

  mcm_poll_ctrl_if bus();

  mcm_poll_ctrl #(
    .PERIOD    (24'(PERIOD)),
    .RQ_LEN    (8'(RQ_LEN)),
    .TIMEOUT   (24'(TIMEOUT))
`ifdef MCM_POLL_RETRY_EN
    ,
    .MAX_RETRY (4'(MAX_RETRY))
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: expected next request start, frame/error counts, retries used
  int exp_rise  = -1;
  int m_frames  = 0;
  int m_errs    = 0;
  int m_retries = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One request attempt; d<0 means the receiver never answers
  task automatic poll(input int d, input bit en_next);
    int  r, w, t_set, rq_len, budget;
    int  fr_c, fr_n, to_c, to_n, er_c, er_n;
    bit  fell, done_ok, retry_now;
    budget = 0;
    while (bus.rq !== 1'b1 && budget < PERIOD + 20) begin
      tick();
      budget++;
    end
    check("rq_rise_seen", int'(bus.rq), 1);
    r = cyc;
    check("rq_rise_cycle", r, exp_rise);
    bus.done = 1'b0;

    done_ok = (d >= 0) && (d < TIMEOUT);
`ifdef MCM_POLL_RETRY_EN
    retry_now = !done_ok && (m_retries < MAX_RETRY);
`else
    retry_now = 1'b0;
`endif
    w     = done_ok ? r + RQ_LEN + d + 3 : r + RQ_LEN + TIMEOUT;
    t_set = (d >= 0) ? r + RQ_LEN + d : -1;

    rq_len = 1; fell = 1'b0;
    fr_c = -1; fr_n = 0; to_c = -1; to_n = 0; er_c = -1; er_n = 0;
    while (cyc < w) begin
      tick();
      if (!fell) begin
        if (bus.rq) rq_len++;
        else fell = 1'b1;
      end
      if (bus.frame_ready) begin fr_n++; fr_c = cyc; end
      if (bus.timeout)     begin to_n++; to_c = cyc; end
      if (bus.err)         begin er_n++; er_c = cyc; end
      if (cyc == r + RQ_LEN) begin
        check("busy_in_wait", int'(bus.busy), 1);
        bus.enable = en_next;
      end
      if (cyc == t_set) bus.done = 1'b1;
    end

    if (done_ok) begin
      m_frames  = (m_frames + 1) % 65536;
      m_retries = 0;
    end else if (retry_now) begin
      m_retries++;
    end else begin
      m_errs    = (m_errs < 255) ? m_errs + 1 : 255;
      m_retries = 0;
    end

    check("rq_width", rq_len, RQ_LEN);
    check("frame_ready_n", fr_n, done_ok ? 1 : 0);
    check("frame_ready_cyc", fr_c, done_ok ? r + RQ_LEN + d + 2 : -1);
    check("timeout_n", to_n, done_ok ? 0 : 1);
    check("timeout_cyc", to_c, done_ok ? -1 : r + RQ_LEN + TIMEOUT);
    check("err_n", er_n, (done_ok || retry_now) ? 0 : 1);
    check("err_cyc", er_c, (done_ok || retry_now) ? -1 : r + RQ_LEN + TIMEOUT);
    check("frame_cnt", int'(bus.frame_cnt), m_frames);
    check("err_cnt", int'(bus.err_cnt), m_errs);
    check("busy_after", int'(bus.busy), retry_now ? 1 : 0);

    if (retry_now)    exp_rise = r + RQ_LEN + TIMEOUT;
    else if (en_next) exp_rise = r + PERIOD;
    else              exp_rise = -1;
  endtask

  // Confirm no request activity for n cycles, then re-enable
  task automatic idle_then_enable(input int n);
    int rq_hi, busy_hi;
    rq_hi = 0; busy_hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.rq)   rq_hi++;
      if (bus.busy) busy_hi++;
    end
    check("idle_rq_cycles", rq_hi, 0);
    check("idle_busy_cycles", busy_hi, 0);
    bus.enable = 1'b1;
    exp_rise   = cyc + 1;
  endtask

  function automatic int rand_delay();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel < 7)       return int'($urandom_range(0, TIMEOUT - 1));
    else if (sel == 7) return TIMEOUT - 1;
    else if (sel == 8) return TIMEOUT;
    else               return -1;
  endfunction

  initial begin
    int budget;
    reset      = 1'b0;
    bus.enable = 1'b0;
    bus.done   = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_rq", int'(bus.rq), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_ready", int'(bus.frame_ready), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_frame_cnt", int'(bus.frame_cnt), 0);
    check("rst_err_cnt", int'(bus.err_cnt), 0);

    // Release with enable high: request starts on the next edge
    reset      = 1'b1;
    bus.enable = 1'b1;
    exp_rise   = cyc + 1;

    poll(200, 1'b1);
    poll(-1, 1'b1);
    poll(-1, 1'b1);
    poll(-1, 1'b1);
    poll(TIMEOUT - 1, 1'b1);
    poll(TIMEOUT, 1'b1);
    poll(0, 1'b1);

    for (int i = 0; i < 6; i++) poll(rand_delay(), 1'b1);

    // Enable dropped mid-WAIT: frame completes, then controller goes idle
    poll(100, 1'b0);
    idle_then_enable(PERIOD + 50);
    poll(int'($urandom_range(0, TIMEOUT - 1)), 1'b1);

    // Reset during the second REQ cycle
    budget = 0;
    while (bus.rq !== 1'b1 && budget < PERIOD + 20) begin
      tick();
      budget++;
    end
    check("rq_rise_cycle_pre_reset", cyc, exp_rise);
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_rq", int'(bus.rq), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_frame_cnt", int'(bus.frame_cnt), 0);
    check("mid_rst_err_cnt", int'(bus.err_cnt), 0);
    tick();
    tick();
    bus.done  = 1'b0;
    reset     = 1'b1;
    m_frames  = 0;
    m_errs    = 0;
    m_retries = 0;
    exp_rise  = cyc + 1;
    poll(int'($urandom_range(0, TIMEOUT - 1)), 1'b1);
    poll(-1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
